// File: rtl/cur_blk_fetch_pkg.sv
// Shared types and geometry constants for the current-block fetch controller.
package me_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int unsigned BLK_SIZE      = 16;
  localparam int unsigned FRAME_WIDTH   = 1920;
  localparam int unsigned FRAME_HEIGHT  = 1080;
  localparam logic [31:0] BASE_ADDR     = 32'd0;
  localparam int unsigned WORDS_PER_ROW = BLK_SIZE / 4;
  localparam int unsigned WORDS_PER_BLK = BLK_SIZE * BLK_SIZE / 4;
endpackage

// File: rtl/cur_blk_fetch_addr_gen.sv
// Row/column walker for one block: produces the byte address of the current
// 4-byte word and flags the end of a row and of the block.
module cur_addr_gen #(
  parameter int unsigned BLK_SIZE    = 16,
  parameter int unsigned FRAME_WIDTH = 1920
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        advance,
  input  logic [31:0] init_base,
  output logic [31:0] addr,
  output logic        last_word,
  output logic        col_last,
  output logic        row_last
);
  localparam int unsigned WPR = BLK_SIZE / 4;
  localparam int CW = $clog2(WPR + 1);
  localparam int RW = $clog2(BLK_SIZE + 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [31:0]   row_base_q, row_base_d;

  assign col_last  = (col_q == CW'(WPR - 1));
  assign row_last  = (row_q == RW'(BLK_SIZE - 1));
  assign last_word = col_last && row_last;
  assign addr      = row_base_q + (32'(col_q) << 2);

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    if (init) begin
      col_d      = '0;
      row_d      = '0;
      row_base_d = init_base;
    end else if (advance) begin
      if (col_last) begin
        col_d      = '0;
        row_d      = row_q + RW'(1);
        row_base_d = row_base_q + FRAME_WIDTH;
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end
endmodule

// File: rtl/cur_blk_fetch.sv
// Current-block fetch controller: reads one block from frame memory and streams
// it over valid/ready. Optional stall counter port under CUR_FETCH_STALL_CNT_EN.
module cur_blk_fetch
  import me_pkg::*;
#(
  parameter int unsigned BLK_SIZE     = me_pkg::BLK_SIZE,
  parameter int unsigned FRAME_WIDTH  = me_pkg::FRAME_WIDTH,
  parameter int unsigned FRAME_HEIGHT = me_pkg::FRAME_HEIGHT,
  parameter logic [31:0] BASE_ADDR    = me_pkg::BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] blk_x,
  input  logic [11:0] blk_y,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef CUR_FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  fetch_state_t state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic        load;
  logic        ag_init, ag_adv;
  logic [31:0] ag_addr, init_base;
  logic        ag_last, ag_col_last, ag_row_last;
  logic [31:0] x_end, y_end;
  logic        range_ok;

  // 32-bit products keep the full frame offset for any 12-bit block index.
  assign x_end     = (32'(blk_x) + 32'd1) * BLK_SIZE;
  assign y_end     = (32'(blk_y) + 32'd1) * BLK_SIZE;
  assign range_ok  = (x_end <= FRAME_WIDTH) && (y_end <= FRAME_HEIGHT);
  assign init_base = BASE_ADDR + 32'(blk_y) * BLK_SIZE * FRAME_WIDTH + 32'(blk_x) * BLK_SIZE;
  assign load      = !out_valid_q || out_ready;

  cur_addr_gen #(
    .BLK_SIZE    (BLK_SIZE),
    .FRAME_WIDTH (FRAME_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (ag_init),
    .advance   (ag_adv),
    .init_base (init_base),
    .addr      (ag_addr),
    .last_word (ag_last),
    .col_last  (ag_col_last),
    .row_last  (ag_row_last)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_en      = 1'b0;
    ag_init     = 1'b0;
    ag_adv      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!range_ok) begin
            err_d = 1'b1;
          end else begin
            ag_init = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        // Memory data is combinational, so a read is only issued when the
        // output register can take the word in the same cycle.
        if (load) begin
          mem_en      = 1'b1;
          mem_addr_d  = ag_addr;
          out_data_d  = mem_data;
          out_valid_d = 1'b1;
          out_last_d  = ag_col_last && ag_row_last;
          ag_adv      = 1'b1;
          if (ag_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign mem_addr  = mem_addr_d;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_valid_q && out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

`ifdef CUR_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && start && range_ok) begin
      stall_cnt_d = '0;
    end else if (state_q != IDLE && out_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_cur_blk_fetch.sv
// Directed bench for cur_blk_fetch: block walks, offsets, stalls, range errors,
// ignored restarts and mid-transfer reset against a byte-pattern memory model.
module tb_cur_blk_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] blk_x = '0;
  logic [11:0] blk_y = '0;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;
`ifdef CUR_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] issued [0:63];
  logic [31:0] rx [0:63];

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {pix(a + 32'd3), pix(a + 32'd2), pix(a + 32'd1), pix(a)};
  endfunction

  function automatic logic [31:0] exp_addr(input int bx, input int by, input int k);
    return 32'(by * 16 * 1920 + bx * 16 + (k / 4) * 1920 + (k % 4) * 4);
  endfunction

  assign mem_data = mem_en ? word_at(mem_addr) : 32'h0;

  cur_blk_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .blk_x     (blk_x),
    .blk_y     (blk_y),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef CUR_FETCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Runs one block; stall_at/stall_len insert a ready gap, restart_at re-pulses start.
  task automatic run_block(input int bx, input int by, input int stall_at,
                           input int stall_len, input int restart_at, input string tag);
    int cyc, iss, acc, stall_left, first_valid, done_cyc;
    bit stall_fired;
    @(negedge clk);
    start = 1'b1; blk_x = 12'(bx); blk_y = 12'(by); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; iss = 0; acc = 0; stall_left = 0; first_valid = -1; done_cyc = -1; stall_fired = 0;
    while (cyc < 300 && done_cyc < 0) begin
      if (cyc == restart_at) begin start = 1'b1; blk_x = 12'd5; end
      else start = 1'b0;
      if (stall_len > 0 && !stall_fired && acc == stall_at) begin
        stall_left = stall_len; stall_fired = 1;
      end
      out_ready = (stall_left == 0);
      #1;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++; $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        end
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (!out_ready) begin
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== exp_addr(bx, by, stall_at) ||
            out_data !== word_at(exp_addr(bx, by, stall_at)) || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL %s stall_hold cyc=%0d: en=%b addr=%0d data=%h valid=%b want en=0 addr=%0d data=%h valid=1",
                   tag, cyc, mem_en, mem_addr, out_data, out_valid,
                   exp_addr(bx, by, stall_at), word_at(exp_addr(bx, by, stall_at)));
        end
      end
      if (mem_en) begin
        checks++;
        if (iss >= 64 || mem_addr !== exp_addr(bx, by, iss)) begin
          failures++;
          $display("FAIL %s mem_addr word=%0d: got %0d want %0d", tag, iss, mem_addr, exp_addr(bx, by, iss));
        end
        if (iss < 64) issued[iss] = mem_addr;
        iss++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (acc >= 64 || out_data !== word_at(exp_addr(bx, by, acc)) || out_last !== (acc == 63)) begin
          failures++;
          $display("FAIL %s out_word=%0d: data=%h last=%b want data=%h last=%b",
                   tag, acc, out_data, out_last, word_at(exp_addr(bx, by, acc)), (acc == 63));
        end
        if (acc < 64) rx[acc] = out_data;
        acc++;
      end
      if (done) begin
        done_cyc = cyc;
        checks++;
        if (busy !== 1'b0) begin
          failures++; $display("FAIL %s busy_at_done: got %b want 0", tag, busy);
        end
      end
      if (stall_left > 0) stall_left--;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (first_valid != 2 || done_cyc != 66 + stall_len || iss != 64 || acc != 64) begin
      failures++;
      $display("FAIL %s timing: first_valid=%0d done=%0d issued=%0d accepted=%0d want 2/%0d/64/64",
               tag, first_valid, done_cyc, iss, acc, 66 + stall_len);
    end
    #1;
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL %s done_single_pulse: done=%b valid=%b want 0/0", tag, done, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_en, out_valid, out_last, busy, done, err} !== 6'b0 || mem_addr !== 32'd0 || out_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: en/valid/last/busy/done/err=%b addr=%0d data=%h want all 0",
               {mem_en, out_valid, out_last, busy, done, err}, mem_addr, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_block0();
    run_block(0, 0, -1, 0, -1, "block0");
    checks++;
    if (issued[1] !== 32'd4 || issued[3] !== 32'd12 || issued[4] !== 32'd1920 || issued[63] !== 32'd28812) begin
      failures++;
      $display("FAIL block0_addrs: got %0d,%0d,%0d,%0d want 4,12,1920,28812", issued[1], issued[3], issued[4], issued[63]);
    end
  endtask

  task automatic test_offset();
    run_block(2, 1, -1, 0, -1, "offset");
    checks++;
    if (issued[0] !== 32'd30752 || issued[4] !== 32'd32672 || rx[0] !== 32'h01000302) begin
      failures++;
      $display("FAIL offset_first: addr0=%0d addr4=%0d data0=%h want 30752 32672 01000302", issued[0], issued[4], rx[0]);
    end
  endtask

  task automatic test_stall();
    run_block(0, 0, 3, 5, -1, "stall");
`ifdef CUR_FETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      failures++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt);
    end
`endif
  endtask

  task automatic test_range_err(input int bx, input int by, input string tag);
    @(negedge clk);
    start = 1'b1; blk_x = 12'(bx); blk_y = 12'(by); out_ready = 1'b1;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin
      failures++; $display("FAIL %s mem_en_on_start: got %b want 0", tag, mem_en);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0) begin
      failures++; $display("FAIL %s err_pulse: err=%b busy=%b en=%b want 1/0/0", tag, err, busy, mem_en);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
        failures++; $display("FAIL %s err_after cyc=%0d: err=%b busy=%b en=%b want 0/0/0", tag, i, err, busy, mem_en);
      end
    end
  endtask

  task automatic test_restart();
    run_block(1, 0, -1, 0, 5, "restart");
  endtask

  task automatic test_reset_mid();
    int acc, cyc;
    @(negedge clk);
    start = 1'b1; blk_x = 12'd0; blk_y = 12'd0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 20 && cyc < 100) begin
      #1;
      if (out_valid && out_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (acc != 20 || out_valid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: acc=%0d valid=%b busy=%b en=%b want 20/0/0/0", acc, out_valid, busy, mem_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_block(0, 0, -1, 0, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_block0();
    test_offset();
    test_stall();
    test_range_err(120, 0, "err_x");
    test_range_err(0, 67, "err_y");
    run_block(119, 66, -1, 0, -1, "edge_blk");
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cur_blk_fetch.md
Name: cur_blk_fetch

Overview:
Fetch controller for the current-frame memory in the motion-estimation datapath.
- On a start request it walks one BLK_SIZE x BLK_SIZE current block, row by row, 4 bytes per access.
- It drives the memory's en/addr pins and registers the returned 32-bit word.
- It streams the words to the PE array over a valid/ready handshake.
- It reports completion, or a range error for out-of-frame blocks.

Parameters:
- BLK_SIZE, 16: block edge in pixels (bytes). Must be a multiple of 4.
- FRAME_WIDTH, 1920: bytes per frame row (row stride).
- FRAME_HEIGHT, 1080: rows per frame.
- BASE_ADDR, 0: byte address of frame pixel (0,0).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle request; sampled only in IDLE.
- blk_x, input, 12: block column index, latched on accepted start.
- blk_y, input, 12: block row index, latched on accepted start.
- mem_en, output, 1: memory enable; 0 forces the memory to return 0.
- mem_addr, output, 32: byte address of the 4-byte read.
- mem_data, input, 32: combinational read data, valid in the same cycle as mem_en/mem_addr.
- out_valid, output, 1: out_data holds a word.
- out_ready, input, 1: consumer accepts the word.
- out_data, output, 32: pixel word; byte 0 = leftmost pixel.
- out_last, output, 1: qualifies the final word of the block.
- busy, output, 1: high from accepted start until done or err.
- done, output, 1: one-cycle pulse after the last word is accepted.
- err, output, 1: one-cycle pulse when the requested block is out of range.

Behaviour:
- Reset: state IDLE; counters 0; every output 0.
- States:
  - IDLE: on start, if (blk_x+1)*BLK_SIZE > FRAME_WIDTH or (blk_y+1)*BLK_SIZE > FRAME_HEIGHT, pulse err next cycle, stay in IDLE, no memory access. Otherwise latch the indices, row_base = BASE_ADDR + blk_y*BLK_SIZE*FRAME_WIDTH + blk_x*BLK_SIZE, col = 0, row = 0, go to FETCH.
  - FETCH: load condition = !out_valid || out_ready. When it holds, mem_en = 1, mem_addr = row_base + 4*col, and mem_data is captured into out_data with out_valid set. Then col advances; at col = BLK_SIZE/4-1, col wraps to 0, row increments and row_base += FRAME_WIDTH. Issuing word BLK_SIZE*BLK_SIZE/4-1 moves the FSM to DRAIN. When the load condition fails, mem_en = 0 and mem_addr holds its value.
  - DRAIN: mem_en = 0. When the last word is accepted (out_valid && out_ready): out_valid = 0, done pulses in the following cycle, go to IDLE.
- Latency: start sampled at edge N; FETCH runs during cycle N+1; out_valid is first high in cycle N+2. With out_ready held high, one word per cycle and 64 words for a 16x16 block. done is high in cycle N+66.
- Stall: while out_valid && !out_ready, out_data, out_last and the counters hold.
- out_last = out_valid && (word is row BLK_SIZE-1, col BLK_SIZE/4-1).
- start outside IDLE is ignored; it is neither queued nor errored.
- Address arithmetic is 32-bit unsigned; the block index product uses at least 24 bits.
- rst_n low mid-transfer: immediate return to IDLE; out_valid and busy drop asynchronously; the pending word is discarded.

Optional Feature:
- Macro CUR_FETCH_STALL_CNT_EN.
- When defined: adds output port stall_cnt (16-bit). It is cleared on accepted start and increments each cycle with out_valid && !out_ready during the block. It saturates at 0xFFFF and holds after done until the next start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package me_pkg:
  - state typedef fetch_state_t {IDLE, FETCH, DRAIN}.
  - Constants BLK_SIZE, FRAME_WIDTH, FRAME_HEIGHT, WORDS_PER_ROW = BLK_SIZE/4, WORDS_PER_BLK.
- Sub-module cur_addr_gen: holds the row/col counters and row_base. Inputs are init and advance. Outputs are addr, last_word and the row/col flags. The top level keeps the FSM and the output register.

Test Plan:
- blk_x=0, blk_y=0, out_ready=1 -> 64 words; addresses 0,4,8,12,1920,...; last address 28812; out_last on word 63; done one cycle after acceptance.
- blk_x=2, blk_y=1 -> first mem_addr 30752, fifth 32672; out_data equals the preloaded bytes little-endian.
- out_ready=0 for 5 cycles at word 3 -> out_data stable, mem_en=0, mem_addr unchanged; resumes at word 4; stall_cnt=5 if the macro is enabled.
- blk_x=120, blk_y=0 -> err pulses once, busy never rises, mem_en stays 0; a following valid start succeeds.
- start re-pulsed with blk_x=5 during FETCH -> ignored; the address stream continues for the original block.
- rst_n low at word 20 -> out_valid=0 and busy=0 immediately; after release, a new start fetches from word 0.
